// File: rtl/decoder_stage_controller_v2_pkg.sv
`default_nettype none
// ============================================================================
// Module  : decoder_stage_controller_v2_pkg
// Brief   : Stage encodings and result-status codes shared by the decoder
//           stage controller and its stage timer.
// Revision: 1.0 - initial release
// ============================================================================
package decoder_stage_controller_v2_pkg;

    localparam int STAGE_WIDTH = 3;

    typedef enum logic [STAGE_WIDTH-1:0] {
        STAGE_IDLE                = 3'd0,
        STAGE_MEASUREMENT_LOADING = 3'd1,
        STAGE_SPREAD              = 3'd2,
        STAGE_SYNC                = 3'd3,
        STAGE_GROW                = 3'd4,
        STAGE_CALC                = 3'd5,
        STAGE_RESULT_WAIT         = 3'd6
    } stage_e;

    localparam logic [1:0] RESULT_OK         = 2'd0;
    localparam logic [1:0] RESULT_DEADLOCK   = 2'd1;
    localparam logic [1:0] RESULT_ITER_LIMIT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/decoder_stage_controller_v2_stage_timer.sv
`default_nettype none
// ============================================================================
// Module  : stage_timer
// Brief   : Per-stage delay counter and cycles-in-stage counter, both cleared
//           on stage entry and saturating; reports delay_done and timeout.
// Revision: 1.0 - initial release
// ============================================================================
module stage_timer #(
    parameter int DELAY_WIDTH     = 4,
    parameter int THRESHOLD_WIDTH = 20
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear_i,
    input  logic                       count_en_i,
    input  logic [DELAY_WIDTH-1:0]     delay_i,
    input  logic [THRESHOLD_WIDTH-1:0] threshold_i,
    output logic                       delay_done_o,
    output logic                       timeout_o
);

    logic [DELAY_WIDTH-1:0]   delay_cnt_q, delay_cnt_d;
    // One extra bit so the counter can exceed the largest threshold
    logic [THRESHOLD_WIDTH:0] cis_q, cis_d, cis_inc;

    always_comb begin
        cis_inc = (cis_q == '1) ? cis_q : cis_q + 1'b1;

        delay_cnt_d = delay_cnt_q;
        cis_d       = cis_q;
        if (clear_i) begin
            delay_cnt_d = '0;
            cis_d       = '0;
        end else begin
            if (delay_cnt_q != '1) begin
                delay_cnt_d = delay_cnt_q + 1'b1;
            end
            if (count_en_i) begin
                cis_d = cis_inc;
            end
        end

        delay_done_o = (delay_cnt_q >= delay_i);
        // cis_inc includes the current cycle, so threshold T trips on cycle T+1
        timeout_o    = count_en_i && (threshold_i != '0) &&
                       (cis_inc > {1'b0, threshold_i});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            delay_cnt_q <= '0;
            cis_q       <= '0;
        end else begin
            delay_cnt_q <= delay_cnt_d;
            cis_q       <= cis_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder_stage_controller_v2.sv
`default_nettype none
// ============================================================================
// Module  : decoder_stage_controller_v2
// Brief   : Union-find decoder round sequencer (load/spread/sync/grow/calc).
//           Optional STAGE_PROFILE_EN adds per-stage cycle profile outputs.
// Revision: 1.0 - initial release
// ============================================================================
module decoder_stage_controller_v2
    import decoder_stage_controller_v2_pkg::*;
#(
    parameter int DELAY_WIDTH             = 4,
    parameter int ITERATION_COUNTER_WIDTH = 8,
    parameter int CYCLE_COUNTER_WIDTH     = 32,
    parameter int THRESHOLD_WIDTH         = 20,
    parameter int CONTEXT_WIDTH           = 2,
    parameter int LOAD_CYCLES             = 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start_valid,
    output logic                               start_ready,
    input  logic [CONTEXT_WIDTH-1:0]           start_context,
    input  logic [DELAY_WIDTH-1:0]             cfg_grow_delay,
    input  logic [DELAY_WIDTH-1:0]             cfg_spread_delay,
    input  logic [DELAY_WIDTH-1:0]             cfg_sync_delay,
    input  logic [THRESHOLD_WIDTH-1:0]         cfg_deadlock_threshold,
    input  logic [ITERATION_COUNTER_WIDTH-1:0] cfg_max_iterations,
    input  logic                               abort,
    input  logic                               has_message_flying,
    input  logic                               has_odd_clusters,
    output logic [STAGE_WIDTH-1:0]             stage,
    output logic [CONTEXT_WIDTH-1:0]           active_context,
    output logic                               calc_go,
    input  logic                               calc_done,
    output logic                               result_valid,
    input  logic                               result_ready,
    output logic [1:0]                         result_status,
    output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
    output logic [CYCLE_COUNTER_WIDTH-1:0]     cycle_counter
`ifdef STAGE_PROFILE_EN
    ,
    output logic [CYCLE_COUNTER_WIDTH-1:0]     prof_spread_cycles,
    output logic [CYCLE_COUNTER_WIDTH-1:0]     prof_sync_cycles,
    output logic [CYCLE_COUNTER_WIDTH-1:0]     prof_grow_cycles
`endif
);

    stage_e                               stage_q, stage_d;
    logic [CONTEXT_WIDTH-1:0]             context_q;
    logic [DELAY_WIDTH-1:0]               grow_delay_q, spread_delay_q, sync_delay_q;
    logic [THRESHOLD_WIDTH-1:0]           threshold_q;
    logic [ITERATION_COUNTER_WIDTH-1:0]   max_iter_q;
    logic [ITERATION_COUNTER_WIDTH-1:0]   iter_q, iter_d, iter_inc;
    logic [CYCLE_COUNTER_WIDTH-1:0]       cycle_q, cycle_d;
    logic [1:0]                           status_q, status_d;
    logic                                 calc_go_q, calc_go_d;

    logic                                 accept;
    logic [DELAY_WIDTH-1:0]               delay_sel;
    logic                                 count_en;
    logic                                 delay_done;
    logic                                 timeout;
    logic                                 stage_change;

    assign accept       = (stage_q == STAGE_IDLE) && start_valid;
    assign stage_change = (stage_d != stage_q);
    assign iter_inc     = (iter_q == '1) ? iter_q : iter_q + 1'b1;

    always_comb begin
        delay_sel = '0;
        count_en  = 1'b0;
        case (stage_q)
            STAGE_MEASUREMENT_LOADING: delay_sel = DELAY_WIDTH'(LOAD_CYCLES - 1);
            STAGE_SPREAD: begin
                delay_sel = spread_delay_q;
                count_en  = 1'b1;
            end
            STAGE_SYNC: begin
                delay_sel = sync_delay_q;
                count_en  = 1'b1;
            end
            STAGE_GROW:   delay_sel = grow_delay_q;
            default:      delay_sel = '0;
        endcase
    end

    stage_timer #(
        .DELAY_WIDTH     (DELAY_WIDTH),
        .THRESHOLD_WIDTH (THRESHOLD_WIDTH)
    ) u_stage_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (stage_change),
        .count_en_i   (count_en),
        .delay_i      (delay_sel),
        .threshold_i  (threshold_q),
        .delay_done_o (delay_done),
        .timeout_o    (timeout)
    );

    always_comb begin
        stage_d  = stage_q;
        iter_d   = iter_q;
        status_d = status_q;
        case (stage_q)
            STAGE_IDLE: begin
                if (start_valid) begin
                    stage_d  = STAGE_MEASUREMENT_LOADING;
                    iter_d   = '0;
                    status_d = RESULT_OK;
                end
            end
            STAGE_MEASUREMENT_LOADING: begin
                if (delay_done) stage_d = STAGE_SPREAD;
            end
            STAGE_SPREAD: begin
                if (delay_done && !has_message_flying) begin
                    stage_d = STAGE_SYNC;
                end else if (timeout && has_message_flying) begin
                    stage_d  = STAGE_RESULT_WAIT;
                    status_d = RESULT_DEADLOCK;
                end
            end
            STAGE_SYNC: begin
                if (delay_done && !has_message_flying) begin
                    iter_d = iter_inc;
                    if (!has_odd_clusters) begin
                        stage_d = STAGE_CALC;
                    end else if ((max_iter_q != '0) && (iter_inc == max_iter_q)) begin
                        stage_d  = STAGE_RESULT_WAIT;
                        status_d = RESULT_ITER_LIMIT;
                    end else begin
                        stage_d = STAGE_GROW;
                    end
                end else if (timeout && has_message_flying) begin
                    stage_d  = STAGE_RESULT_WAIT;
                    status_d = RESULT_DEADLOCK;
                end
            end
            STAGE_GROW: begin
                if (delay_done) stage_d = STAGE_SPREAD;
            end
            STAGE_CALC: begin
                if (calc_done) begin
                    stage_d  = STAGE_RESULT_WAIT;
                    status_d = RESULT_OK;
                end
            end
            STAGE_RESULT_WAIT: begin
                if (result_ready) stage_d = STAGE_IDLE;
            end
            default: stage_d = STAGE_IDLE;
        endcase

        if (abort && (stage_q != STAGE_IDLE)) begin
            stage_d = STAGE_IDLE;
        end

        calc_go_d = (stage_d == STAGE_CALC) && (stage_q != STAGE_CALC);

        // Counting stops on the edge into RESULT_WAIT, so the held value is the work cycles
        cycle_d = cycle_q;
        if (accept) begin
            cycle_d = CYCLE_COUNTER_WIDTH'(1);
        end else if ((stage_q != STAGE_IDLE) && (stage_q != STAGE_RESULT_WAIT) &&
                     (stage_d != STAGE_IDLE) && (stage_d != STAGE_RESULT_WAIT) &&
                     (cycle_q != '1)) begin
            cycle_d = cycle_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q        <= STAGE_IDLE;
            context_q      <= '0;
            grow_delay_q   <= '0;
            spread_delay_q <= '0;
            sync_delay_q   <= '0;
            threshold_q    <= '0;
            max_iter_q     <= '0;
            iter_q         <= '0;
            cycle_q        <= '0;
            status_q       <= RESULT_OK;
            calc_go_q      <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            iter_q    <= iter_d;
            cycle_q   <= cycle_d;
            status_q  <= status_d;
            calc_go_q <= calc_go_d;
            if (accept) begin
                context_q      <= start_context;
                grow_delay_q   <= cfg_grow_delay;
                spread_delay_q <= cfg_spread_delay;
                sync_delay_q   <= cfg_sync_delay;
                threshold_q    <= cfg_deadlock_threshold;
                max_iter_q     <= cfg_max_iterations;
            end
        end
    end

`ifdef STAGE_PROFILE_EN
    logic [CYCLE_COUNTER_WIDTH-1:0] prof_spread_q, prof_sync_q, prof_grow_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prof_spread_q <= '0;
            prof_sync_q   <= '0;
            prof_grow_q   <= '0;
        end else if (accept) begin
            prof_spread_q <= '0;
            prof_sync_q   <= '0;
            prof_grow_q   <= '0;
        end else begin
            if ((stage_q == STAGE_SPREAD) && (prof_spread_q != '1)) prof_spread_q <= prof_spread_q + 1'b1;
            if ((stage_q == STAGE_SYNC)   && (prof_sync_q   != '1)) prof_sync_q   <= prof_sync_q + 1'b1;
            if ((stage_q == STAGE_GROW)   && (prof_grow_q   != '1)) prof_grow_q   <= prof_grow_q + 1'b1;
        end
    end

    assign prof_spread_cycles = prof_spread_q;
    assign prof_sync_cycles   = prof_sync_q;
    assign prof_grow_cycles   = prof_grow_q;
`endif

    assign start_ready       = (stage_q == STAGE_IDLE);
    assign stage             = stage_q;
    assign active_context    = context_q;
    assign calc_go           = calc_go_q;
    assign result_valid      = (stage_q == STAGE_RESULT_WAIT);
    assign result_status     = status_q;
    assign iteration_counter = iter_q;
    assign cycle_counter     = cycle_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_stage_controller_v2.sv
`default_nettype none
// ============================================================================
// Module  : tb_decoder_stage_controller_v2
// Brief   : Self-checking bench: directed corner rounds plus randomized rounds
//           predicted from stage-duration arithmetic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_decoder_stage_controller_v2;
    import decoder_stage_controller_v2_pkg::*;

    localparam int DW = 4, IW = 8, CW = 32, TW = 20, XW = 2, LC = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [XW-1:0] start_context = '0;
    logic [DW-1:0] cfg_grow_delay = '0, cfg_spread_delay = '0, cfg_sync_delay = '0;
    logic [TW-1:0] cfg_deadlock_threshold = '0;
    logic [IW-1:0] cfg_max_iterations = '0;
    logic          abort = 1'b0, has_message_flying = 1'b0, has_odd_clusters = 1'b0;
    logic [2:0]    stage;
    logic [XW-1:0] active_context;
    logic          calc_go, calc_done = 1'b0, result_valid, result_ready = 1'b0;
    logic [1:0]    result_status;
    logic [IW-1:0] iteration_counter;
    logic [CW-1:0] cycle_counter;
`ifdef STAGE_PROFILE_EN
    logic [CW-1:0] prof_spread_cycles, prof_sync_cycles, prof_grow_cycles;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decoder_stage_controller_v2 #(
        .DELAY_WIDTH(DW), .ITERATION_COUNTER_WIDTH(IW), .CYCLE_COUNTER_WIDTH(CW),
        .THRESHOLD_WIDTH(TW), .CONTEXT_WIDTH(XW), .LOAD_CYCLES(LC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_ready(start_ready),
        .start_context(start_context), .cfg_grow_delay(cfg_grow_delay),
        .cfg_spread_delay(cfg_spread_delay), .cfg_sync_delay(cfg_sync_delay),
        .cfg_deadlock_threshold(cfg_deadlock_threshold), .cfg_max_iterations(cfg_max_iterations),
        .abort(abort), .has_message_flying(has_message_flying), .has_odd_clusters(has_odd_clusters),
        .stage(stage), .active_context(active_context), .calc_go(calc_go), .calc_done(calc_done),
        .result_valid(result_valid), .result_ready(result_ready), .result_status(result_status),
        .iteration_counter(iteration_counter), .cycle_counter(cycle_counter)
`ifdef STAGE_PROFILE_EN
        , .prof_spread_cycles(prof_spread_cycles), .prof_sync_cycles(prof_sync_cycles),
        .prof_grow_cycles(prof_grow_cycles)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round(input int ds, input int dy, input int dg, input int mi,
                               input int thr, input logic [XW-1:0] ctx);
        cfg_spread_delay       = DW'(ds);
        cfg_sync_delay         = DW'(dy);
        cfg_grow_delay         = DW'(dg);
        cfg_max_iterations     = IW'(mi);
        cfg_deadlock_threshold = TW'(thr);
        start_context          = ctx;
        start_valid            = 1'b1;
        step();
        start_valid = 1'b0;
        check("accept_loading", stage, STAGE_MEASUREMENT_LOADING);
    endtask

    task automatic consume();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check("consumed_valid", result_valid, 0);
        check("consumed_idle", stage, STAGE_IDLE);
        check("consumed_ready", start_ready, 1);
    endtask

    // Environment: odd clusters persist for the first nodd SYNC exits; calc_done
    // arrives lat cycles after calc_go. Outcome predicted from stage durations.
    task automatic run_round(input int ds, input int dy, input int dg, input int mi,
                             input int nodd, input int lat, input int hold,
                             input logic [XW-1:0] ctx);
        int     n_sp, n_sy, n_gr, exp_iter, exp_cyc, exp_go, gos, ck;
        logic [1:0] exp_st;
        logic [CW-1:0] cyc_seen;
        if (mi != 0 && mi <= nodd) begin
            exp_st = RESULT_ITER_LIMIT; exp_iter = mi;
            n_sp = mi; n_sy = mi; n_gr = mi - 1; exp_go = 0;
        end else begin
            exp_st = RESULT_OK; exp_iter = nodd + 1;
            n_sp = nodd + 1; n_sy = nodd + 1; n_gr = nodd; exp_go = 1;
        end
        exp_cyc = LC + n_sp * (ds + 1) + n_sy * (dy + 1) + n_gr * (dg + 1) + exp_go * (lat + 1);
        has_message_flying = 1'b0;
        start_round(ds, dy, dg, mi, $urandom_range(0, 3), ctx);
        gos = 0; ck = 0;
        for (int k = 0; k < 3000 && !result_valid; k++) begin
            cfg_spread_delay       = DW'($urandom);
            cfg_sync_delay         = DW'($urandom);
            cfg_grow_delay         = DW'($urandom);
            cfg_max_iterations     = IW'($urandom);
            cfg_deadlock_threshold = TW'($urandom);
            start_context          = XW'($urandom);
            start_valid            = 1'($urandom);
            if (calc_go) gos++;
            if (stage == STAGE_CALC) begin
                calc_done = (ck == lat);
                ck++;
            end else begin
                calc_done = 1'b0;
            end
            has_odd_clusters = (int'(iteration_counter) < nodd);
            step();
        end
        start_valid = 1'b0;
        calc_done   = 1'b0;
        check("result_valid", result_valid, 1);
        check("status", result_status, exp_st);
        check("iterations", iteration_counter, exp_iter);
        check("cycles", cycle_counter, exp_cyc);
        check("context", active_context, ctx);
        check("calc_go_pulses", gos, exp_go);
`ifdef STAGE_PROFILE_EN
        check("prof_spread", prof_spread_cycles, n_sp * (ds + 1));
        check("prof_sync", prof_sync_cycles, n_sy * (dy + 1));
        check("prof_grow", prof_grow_cycles, n_gr * (dg + 1));
`endif
        cyc_seen = CW'(exp_cyc);
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_valid", result_valid, 1);
            check("hold_status", result_status, exp_st);
            check("hold_cycles", cycle_counter, cyc_seen);
            check("hold_iter", iteration_counter, exp_iter);
            check("hold_start_ready", start_ready, 0);
        end
        consume();
        check("idle_context", active_context, ctx);
    endtask

    initial begin
        int n_sp, gos;
        step();
        step();
        check("rst_stage", stage, STAGE_IDLE);
        check("rst_start_ready", start_ready, 1);
        check("rst_valid", result_valid, 0);
        check("rst_calc_go", calc_go, 0);
        check("rst_iter", iteration_counter, 0);
        check("rst_cycles", cycle_counter, 0);
        reset_n = 1'b1;
        step();

        // Nominal round with context 3 and a long result hold
        run_round(2, 3, 1, 0, 3, 2, 20, 2'd3);
        // Iteration cap reached with odd clusters stuck
        run_round(1, 1, 1, 2, 255, 0, 1, 2'd1);
        // calc_done on the calc_go cycle itself
        run_round(0, 0, 0, 0, 0, 0, 0, 2'd2);

        // Deadlock: threshold 10, PU array never drains in SPREAD
        has_message_flying = 1'b1;
        has_odd_clusters   = 1'b0;
        start_round(0, 0, 0, 0, 10, 2'd0);
        n_sp = 0; gos = 0;
        for (int k = 0; k < 200 && !result_valid; k++) begin
            if (stage == STAGE_SPREAD) n_sp++;
            if (calc_go) gos++;
            step();
        end
        check("dl_valid", result_valid, 1);
        check("dl_status", result_status, RESULT_DEADLOCK);
        check("dl_spread_cycles", n_sp, 11);
        check("dl_cycles", cycle_counter, LC + 11);
        check("dl_calc_go", gos, 0);
        consume();

        // Threshold 0 disables detection; abort clears the stuck round
        start_round(0, 0, 0, 0, 0, 2'd1);
        repeat (60) step();
        check("nodl_stage", stage, STAGE_SPREAD);
        check("nodl_valid", result_valid, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_spread_idle", stage, STAGE_IDLE);
        has_message_flying = 1'b0;

        // Abort in GROW
        has_odd_clusters = 1'b1;
        start_round(0, 0, 5, 0, 0, 2'd2);
        for (int k = 0; k < 100 && stage != STAGE_GROW; k++) step();
        check("reach_grow", stage, STAGE_GROW);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_grow_idle", stage, STAGE_IDLE);
        check("abort_grow_valid", result_valid, 0);
        repeat (5) step();
        check("abort_grow_no_result", result_valid, 0);

        // Abort together with a start in IDLE: the start wins
        abort       = 1'b1;
        start_valid = 1'b1;
        step();
        abort       = 1'b0;
        start_valid = 1'b0;
        check("abort_start_accept", stage, STAGE_MEASUREMENT_LOADING);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_loading_idle", stage, STAGE_IDLE);

        // Asynchronous reset while in SYNC
        start_round(0, 15, 0, 0, 0, 2'd3);
        for (int k = 0; k < 100 && stage != STAGE_SYNC; k++) step();
        check("reach_sync", stage, STAGE_SYNC);
        step();
        #2 reset_n = 1'b0;
        #1;
        check("arst_stage", stage, STAGE_IDLE);
        check("arst_start_ready", start_ready, 1);
        check("arst_context", active_context, 0);
        check("arst_cycles", cycle_counter, 0);
        check("arst_valid", result_valid, 0);
        has_odd_clusters = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        check("arst_still_idle", stage, STAGE_IDLE);

        for (int r = 0; r < 12; r++) begin
            run_round($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 4),
                      $urandom_range(0, 5), XW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decoder_stage_controller_v2.md
Name: decoder_stage_controller_v2

Overview:
Parametrised successor stage controller for the union-find decoder array. It sequences one decoding round through load → spread → sync → grow iterations, then result calculation.
- Decided at round start: stage delays, deadlock threshold and iteration cap are latched from config ports.
- Handshakes: rounds are accepted with a valid/ready handshake tagged by context ID; the result is held under valid/ready backpressure.
- Placement: sits between the round scheduler and the PU array / boundary-cardinality calculator.

Parameters:
- DELAY_WIDTH, 4, width of each programmable stage-delay field.
- ITERATION_COUNTER_WIDTH, 8, iteration counter and cap width.
- CYCLE_COUNTER_WIDTH, 32, round cycle counter width.
- THRESHOLD_WIDTH, 20, deadlock threshold width.
- CONTEXT_WIDTH, 2, round context tag width (up to 4 interleaved rounds).
- LOAD_CYCLES, 1, cycles spent in STAGE_MEASUREMENT_LOADING (≥1).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start_valid  in  1  round request
- start_ready  out  1  controller can accept a round
- start_context  in  CONTEXT_WIDTH  tag of requested round
- cfg_grow_delay / cfg_spread_delay / cfg_sync_delay  in  DELAY_WIDTH each  minimum stage cycles
- cfg_deadlock_threshold  in  THRESHOLD_WIDTH  0 = detection disabled
- cfg_max_iterations  in  ITERATION_COUNTER_WIDTH  0 = unlimited
- abort  in  1  synchronous kill of the current round
- has_message_flying  in  1  PU array busy
- has_odd_clusters  in  1  odd cluster exists
- stage  out  STAGE_WIDTH  current stage
- active_context  out  CONTEXT_WIDTH  tag of the round in flight
- calc_go  out  1  one-cycle pulse to the cardinality calculator
- calc_done  in  1  calculator finished
- result_valid  out  1  result held
- result_ready  in  1  consumer accepts
- result_status  out  2  0 OK, 1 DEADLOCK, 2 ITER_LIMIT
- iteration_counter  out  ITERATION_COUNTER_WIDTH  iterations completed
- cycle_counter  out  CYCLE_COUNTER_WIDTH  round cycles

Behaviour:
- Reset (async, reset_n low):
  - stage=IDLE; start_ready=1.
  - calc_go, result_valid, result_status, iteration_counter, cycle_counter, active_context, all internal counters = 0.
  - Reset mid-round discards the round immediately; no result is produced.
- States:
  - IDLE → LOADING on start_valid&&start_ready. That cycle latches all cfg_* and start_context. start_ready=1 only in IDLE.
  - LOADING: stays LOAD_CYCLES cycles → SPREAD.
  - SPREAD: once delay_cnt≥cfg_spread_delay and !has_message_flying → SYNC.
  - SYNC: once delay_cnt≥cfg_sync_delay and !has_message_flying:
    - iteration_counter+1 (saturating).
    - If has_odd_clusters: → GROW, unless the new count equals a nonzero cfg_max_iterations, in which case → RESULT_WAIT with ITER_LIMIT.
    - Else → CALC.
  - GROW: once delay_cnt≥cfg_grow_delay → SPREAD.
  - CALC: calc_go=1 on the entry cycle only; wait for calc_done → RESULT_WAIT with OK. calc_done on the entry cycle itself is honoured.
  - RESULT_WAIT: result_valid=1; status, counters and context stay stable. On result_ready → IDLE, result_valid=0 the next cycle.
- Stage delay counting:
  - delay_cnt clears on every stage entry and saturates at all-ones.
  - Delay 0 still means the stage lasts ≥1 cycle.
- Deadlock detection:
  - cycles_in_stage clears on entry to SPREAD/SYNC and increments while in them.
  - cycles_in_stage > nonzero threshold while has_message_flying → RESULT_WAIT with DEADLOCK. No calc_go is issued.
- cycle_counter: =1 on LOADING entry; +1 each cycle until RESULT_WAIT; saturates; frozen while result_valid.
- abort: from any non-IDLE stage → IDLE next cycle. No result is produced; a pending result is dropped.
- Simultaneous events:
  - abort with start_valid in IDLE: the start is accepted (abort is ignored in IDLE).
  - Deadlock and normal exit in the same cycle: the normal exit wins.

Optional Feature:
STAGE_PROFILE_EN.
- Defined: adds outputs prof_spread_cycles, prof_sync_cycles, prof_grow_cycles (CYCLE_COUNTER_WIDTH each).
  - Each counts cycles spent in its stage this round.
  - Cleared on LOADING entry; saturating; frozen and valid with result_valid.
- Undefined: ports and counters are absent; no other behaviour change.

Decomposition:
- The shared parameters package already holds the STAGE_* encodings and STAGE_WIDTH. Add STAGE_RESULT_WAIT there.
- Also add result-status localparams RESULT_OK/RESULT_DEADLOCK/RESULT_ITER_LIMIT to the package.
- One sub-module, stage_timer: delay counter plus cycles_in_stage with clear-on-entry and saturation. It reports delay_done and timeout flags.

Test Plan:
- Delays 1/2/3, cap 0, threshold 0. Odd clusters for 3 SYNC exits, then clear; calc_done 2 cycles after calc_go → status OK, iteration_counter=4, one calc_go pulse, result held until result_ready.
- cfg_max_iterations=2 with has_odd_clusters stuck at 1 → status ITER_LIMIT, iteration_counter=2, no calc_go.
- Threshold 10 with has_message_flying stuck in SPREAD → DEADLOCK result after 11 SPREAD cycles; threshold 0 → no exit ever.
- result_ready held low 20 cycles → result_valid, status, counters and cycle_counter stable; start_ready=0 throughout.
- abort in GROW → IDLE next cycle, result_valid stays 0. reset_n pulsed in SYNC → all outputs zero asynchronously, stage=IDLE.
- cfg changes mid-round and start_context=3 → round uses values latched at accept; active_context=3 until IDLE.
